// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state type, opcode fields and decode helpers for the CPU sequencer
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_HI,
        ST_FETCH_LO,
        ST_FETCH_DATA,
        ST_RAM_READ,
        ST_EXEC,
        ST_STORE,
        ST_SKIP_HI,
        ST_SKIP_LO
    } seq_state_t;

    localparam logic [15:0] ONE_ARG_MASK = 16'hC000;
    localparam logic [15:0] ONE_ARG_VAL  = 16'h8000;
    localparam logic [15:0] SRC_MASK     = 16'h0600;
    localparam logic [15:0] SRC_DATA     = 16'h0200;
    localparam logic [4:0]  OP_STORE     = 5'b10010;

    function automatic logic needs_data(input logic [15:0] inst);
        return ((inst & ONE_ARG_MASK) == ONE_ARG_VAL) && ((inst & SRC_MASK) == SRC_DATA);
    endfunction

    // Stores also have bit 10 set but take their operand from the accumulator.
    function automatic logic needs_ram(input logic [15:0] inst);
        return ((inst & ONE_ARG_MASK) == ONE_ARG_VAL) && inst[10] && (inst[15:11] != OP_STORE);
    endfunction

    function automatic logic [1:0] inst_len(input logic [7:0] hi_byte);
        return needs_data({hi_byte, 8'h00}) ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/cpu_sequencer_bus_port.sv
// rtl/cpu_sequencer_bus_port.sv - holds one memory request (address, direction, write byte) until acked
module bus_port
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [7:0]        issue_wdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              done
);

    // An ack with no request outstanding is not a completion.
    assign done = mem_req & mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= issue_we;
            mem_addr  <= issue_addr;
            mem_wdata <= issue_wdata;
        end else if (done) begin
            mem_req   <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/execute controller: instruction fetch, operand access, decode enable, PC flow
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(16'h8000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              dec_en,
    output logic [15:0]       dec_inst,
    output logic [7:0]        dec_data,
    input  logic              dec_branch,
    input  logic              dec_store,
    input  logic              dec_if,
    input  logic              dec_if_zero,
    input  logic              dec_if_not_zero,
    input  logic              dec_if_else,
    input  logic              dec_if_not_else,
    input  logic [15:0]       dec_rhs,
    input  logic              acc_zero,
    input  logic              else_flag,
    input  logic [7:0]        acc_lo,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [15:0]       inst_nxt;
    logic [7:0]        data_nxt;
    logic [7:0]        skip_hi, skip_hi_nxt;
    logic              advance;
    logic              cond_ok;
    logic              issue;
    logic              issue_we;
    logic [ADDR_W-1:0] issue_addr;
    logic              bus_done;

    bus_port #(.ADDR_W(ADDR_W)) u_bus_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (issue),
        .issue_we    (issue_we),
        .issue_addr  (issue_addr),
        .issue_wdata (acc_lo),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .done        (bus_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH_HI;
            pc       <= RESET_PC;
            dec_inst <= 16'h0000;
            dec_data <= 8'h00;
            skip_hi  <= 8'h00;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            dec_inst <= inst_nxt;
            dec_data <= data_nxt;
            skip_hi  <= skip_hi_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        inst_nxt    = dec_inst;
        data_nxt    = dec_data;
        skip_hi_nxt = skip_hi;
        advance     = 1'b0;
        cond_ok     = 1'b1;
        dec_en      = 1'b0;

        case (state)
            ST_FETCH_HI: begin
                if (bus_done) begin
                    inst_nxt[15:8] = mem_rdata;
                    pc_nxt         = pc + ADDR_W'(1);
                    state_nxt      = ST_FETCH_LO;
                    advance        = 1'b1;
                end
            end
            ST_FETCH_LO: begin
                if (bus_done) begin
                    inst_nxt[7:0] = mem_rdata;
                    pc_nxt        = pc + ADDR_W'(1);
                    advance       = 1'b1;
                    if (needs_data(inst_nxt))
                        state_nxt = ST_FETCH_DATA;
                    else if (needs_ram(inst_nxt))
                        state_nxt = ST_RAM_READ;
                    else
                        state_nxt = ST_EXEC;
                end
            end
            ST_FETCH_DATA: begin
                if (bus_done) begin
                    data_nxt  = mem_rdata;
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = ST_EXEC;
                    advance   = 1'b1;
                end
            end
            ST_RAM_READ: begin
                if (bus_done) begin
                    data_nxt  = mem_rdata;
                    state_nxt = ST_EXEC;
                    advance   = 1'b1;
                end
            end
            ST_EXEC: begin
                dec_en  = 1'b1;
                advance = 1'b1;
                // pc already points past the instruction, so the offset is relative to that.
                if (dec_branch)
                    pc_nxt = pc + dec_rhs[ADDR_W-1:0];
                if (dec_if_zero)
                    cond_ok = acc_zero;
                else if (dec_if_not_zero)
                    cond_ok = !acc_zero;
                else if (dec_if_else)
                    cond_ok = else_flag;
                else if (dec_if_not_else)
                    cond_ok = !else_flag;
                if (dec_store && dec_inst[10])
                    state_nxt = ST_STORE;
                else if (dec_if && !cond_ok)
                    state_nxt = ST_SKIP_HI;
                else
                    state_nxt = ST_FETCH_HI;
            end
            ST_STORE: begin
                if (bus_done) begin
                    state_nxt = ST_FETCH_HI;
                    advance   = 1'b1;
                end
            end
            ST_SKIP_HI: begin
                if (bus_done) begin
                    skip_hi_nxt = mem_rdata;
                    pc_nxt      = pc + ADDR_W'(1);
                    state_nxt   = ST_SKIP_LO;
                    advance     = 1'b1;
                end
            end
            ST_SKIP_LO: begin
                // pc sits on the skipped low byte; step over it and any data byte.
                if (bus_done) begin
                    pc_nxt    = pc + ADDR_W'(inst_len(skip_hi)) - ADDR_W'(1);
                    state_nxt = ST_FETCH_HI;
                    advance   = 1'b1;
                end
            end
            default: state_nxt = ST_FETCH_HI;
        endcase

        // Each bus state's request is launched on the edge that enters it.
        issue = 1'b0;
        if (advance)
            issue = (state_nxt != ST_EXEC) && ((state_nxt != ST_FETCH_HI) || run);
        else if (state == ST_FETCH_HI && !mem_req)
            issue = run;

        issue_we   = (state_nxt == ST_STORE);
        issue_addr = (state_nxt == ST_RAM_READ || state_nxt == ST_STORE)
                   ? (RAM_BASE | ADDR_W'(inst_nxt[7:0])) : pc_nxt;
    end

    assign busy = !(state == ST_FETCH_HI && !mem_req);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized and directed check of cpu_sequencer against a behavioural model
module tb_cpu_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] RAM_BASE = 16'h8000;

    logic        clk = 1'b0;
    logic        rst_n, run;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        dec_en;
    logic [15:0] dec_inst, dec_rhs;
    logic [7:0]  dec_data;
    logic        dec_branch, dec_store, dec_if;
    logic        dec_if_zero, dec_if_not_zero, dec_if_else, dec_if_not_else;
    logic        acc_zero, else_flag;
    logic [7:0]  acc_lo;
    logic [15:0] pc;
    logic        busy;

    always #5 clk = ~clk;

    cpu_sequencer #(.ADDR_W(16), .RESET_PC(RESET_PC), .RAM_BASE(RAM_BASE)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dec_en(dec_en), .dec_inst(dec_inst), .dec_data(dec_data),
        .dec_branch(dec_branch), .dec_store(dec_store), .dec_if(dec_if),
        .dec_if_zero(dec_if_zero), .dec_if_not_zero(dec_if_not_zero),
        .dec_if_else(dec_if_else), .dec_if_not_else(dec_if_not_else),
        .dec_rhs(dec_rhs), .acc_zero(acc_zero), .else_flag(else_flag), .acc_lo(acc_lo),
        .pc(pc), .busy(busy)
    );

    // Toy decoder: 0xC? branch by signed low byte, 10010 store, 0xE? conditional with select in [2:0].
    assign dec_branch      = dec_inst[15:12] == 4'hC;
    assign dec_rhs         = {{8{dec_inst[7]}}, dec_inst[7:0]};
    assign dec_store       = dec_inst[15:11] == 5'b10010;
    assign dec_if          = dec_inst[15:12] == 4'hE;
    assign dec_if_zero     = dec_if && dec_inst[2:0] == 3'd1;
    assign dec_if_not_zero = dec_if && dec_inst[2:0] == 3'd2;
    assign dec_if_else     = dec_if && dec_inst[2:0] == 3'd3;
    assign dec_if_not_else = dec_if && dec_inst[2:0] == 3'd4;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  mem  [65536];
    logic [7:0]  mmem [65536];
    logic [24:0] exp_txn[$], obs_txn[$];
    logic [39:0] exp_exec[$], obs_exec[$];
    int          obs_cyc[$];
    int          cyc = 0;
    int          dmin = 0, dmax = 0, cur_delay = 0, waitc = 0;
    bit          in_req = 0, stale_ack = 0;
    logic [15:0] req_addr;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus slave and monitor: acks after a random wait, records completed transfers and decode pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack = 1'b0;
            waitc   = 0;
            in_req  = 0;
        end else begin
            if (dec_en) begin
                obs_exec.push_back({dec_inst, dec_data, pc});
                obs_cyc.push_back(cyc);
                check("req_in_exec", mem_req, 1'b0);
            end
            if (mem_req || dec_en) check("busy_active", busy, 1'b1);
            if (mem_ack) mem_ack = 1'b0;
            if (stale_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'h5A;
                stale_ack = 0;
            end else if (mem_req) begin
                if (!in_req) begin
                    in_req    = 1;
                    waitc     = 0;
                    req_addr  = mem_addr;
                    cur_delay = $urandom_range(dmax, dmin);
                end
                if (waitc >= cur_delay) begin
                    check("addr_stable", mem_addr, req_addr);
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        obs_txn.push_back({1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem[mem_addr];
                        obs_txn.push_back({1'b0, mem_addr, 8'h00});
                    end
                    in_req = 0;
                end else begin
                    waitc++;
                end
            end
        end
    end

    function automatic logic [39:0] exec_at(input int i);
        return (i < obs_exec.size()) ? obs_exec[i] : 40'hFF_FFFF_FFFF;
    endfunction

    function automatic logic [24:0] txn_at(input int i);
        return (i < obs_txn.size()) ? obs_txn[i] : 25'h1FF_FFFF;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < obs_cyc.size()) ? obs_cyc[i] : -1000;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    endtask

    task automatic sync_model();
        for (int i = 0; i < 65536; i++) mmem[i] = mem[i];
    endtask

    // Walks the program instruction by instruction and lists every bus transfer and decode event.
    task automatic build_model(input int n);
        logic [15:0] p, inst, a;
        logic [7:0]  d, hi;
        bit          cond;
        exp_txn.delete();
        exp_exec.delete();
        p = RESET_PC;
        d = 8'h00;
        for (int k = 0; k < n; k++) begin
            exp_txn.push_back({1'b0, p, 8'h00});
            hi = mmem[p];
            p  = p + 16'd1;
            exp_txn.push_back({1'b0, p, 8'h00});
            inst = {hi, mmem[p]};
            p    = p + 16'd1;
            if (inst[15:14] == 2'b10 && inst[10:9] == 2'b01) begin
                exp_txn.push_back({1'b0, p, 8'h00});
                d = mmem[p];
                p = p + 16'd1;
            end else if (inst[15:14] == 2'b10 && inst[10] && inst[15:11] != 5'b10010) begin
                a = RAM_BASE | {8'h00, inst[7:0]};
                exp_txn.push_back({1'b0, a, 8'h00});
                d = mmem[a];
            end
            exp_exec.push_back({inst, d, p});
            if (inst[15:12] == 4'hC) p = p + {{8{inst[7]}}, inst[7:0]};
            if (inst[15:11] == 5'b10010 && inst[10]) begin
                a = RAM_BASE | {8'h00, inst[7:0]};
                exp_txn.push_back({1'b1, a, acc_lo});
                mmem[a] = acc_lo;
            end else if (inst[15:12] == 4'hE) begin
                case (inst[2:0])
                    3'd1:    cond = acc_zero;
                    3'd2:    cond = !acc_zero;
                    3'd3:    cond = else_flag;
                    3'd4:    cond = !else_flag;
                    default: cond = 1;
                endcase
                if (!cond) begin
                    hi = mmem[p];
                    exp_txn.push_back({1'b0, p, 8'h00});
                    exp_txn.push_back({1'b0, p + 16'd1, 8'h00});
                    p = p + ((hi[7:6] == 2'b10 && hi[2:1] == 2'b01) ? 16'd3 : 16'd2);
                end
            end
        end
    endtask

    task automatic run_and_compare(input string name, input int n, input bit rand_run);
        int budget;
        build_model(n);
        obs_txn.delete();
        obs_exec.delete();
        obs_cyc.delete();
        if (!rst_n) begin
            @(negedge clk);
            rst_n = 1'b1;
        end
        run    = 1'b1;
        budget = 0;
        while ((obs_txn.size() < exp_txn.size() || obs_exec.size() < n) && budget < 4000) begin
            @(negedge clk);
            #1;
            if (rand_run) run = ($urandom_range(0, 3) != 0);
            budget++;
        end
        run = 1'b1;
        check({name, "_done"}, budget < 4000, 1'b1);
        for (int i = 0; i < exp_txn.size(); i++)
            check($sformatf("%s_txn%0d", name, i), txn_at(i), exp_txn[i]);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_exec%0d", name, i), exec_at(i), exp_exec[i]);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req"},  mem_req, 1'b0);
        check({tag, "_busy"}, busy,    1'b0);
        check({tag, "_den"},  dec_en,  1'b0);
        check({tag, "_pc"},   pc,      RESET_PC);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        acc_zero = 1'b0; else_flag = 1'b0; acc_lo = 8'h00;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_addr", mem_addr, 16'h0000);
        check("reset_we",   mem_we,   1'b0);
        check("reset_inst", dec_inst, 16'h0000);
        check("reset_data", dec_data, 8'h00);

        // Plain ALU instructions on a one-wait bus: five cycles apart.
        clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h06;
        sync_model();
        dmin = 1; dmax = 1;
        run_and_compare("alu", 2, 0);
        check("alu_first", exec_at(0), {16'h0005, 8'h00, 16'h0002});
        check("alu_next_fetch", txn_at(2), {1'b0, 16'h0002, 8'h00});
        check("alu_latency", cyc_at(1) - cyc_at(0), 5);
        hold_reset();

        // Immediate data byte: three reads, seven cycles apart.
        clear_mem();
        mem[0] = 8'h82; mem[1] = 8'h00; mem[2] = 8'h7F;
        mem[3] = 8'h82; mem[4] = 8'h00; mem[5] = 8'h7E;
        sync_model();
        run_and_compare("imm", 2, 0);
        check("imm_first", exec_at(0), {16'h8200, 8'h7F, 16'h0003});
        check("imm_latency", cyc_at(1) - cyc_at(0), 7);
        hold_reset();

        // RAM operand read followed by a store.
        clear_mem();
        mem[0] = 8'h84; mem[1] = 8'h10; mem[2] = 8'h94; mem[3] = 8'h20;
        mem[16'h8010] = 8'hAA;
        acc_lo = 8'h3C;
        sync_model();
        dmin = 0; dmax = 2;
        run_and_compare("ram", 2, 0);
        check("ram_read", txn_at(2), {1'b0, 16'h8010, 8'h00});
        check("ram_first", exec_at(0), {16'h8410, 8'hAA, 16'h0002});
        check("ram_store", txn_at(5), {1'b1, 16'h8020, 8'h3C});
        hold_reset();

        // Branch chain 0 -> 0x80 -> 0x100, then a -2 branch back onto itself.
        clear_mem();
        mem[0] = 8'hC0; mem[1] = 8'h7E;
        mem[16'h0080] = 8'hC0; mem[16'h0081] = 8'h7E;
        mem[16'h0100] = 8'hC0; mem[16'h0101] = 8'hFE;
        sync_model();
        run_and_compare("branch", 4, 0);
        check("branch_back", txn_at(6), {1'b0, 16'h0100, 8'h00});
        hold_reset();

        // False if skips a three-byte instruction without decoding it.
        clear_mem();
        mem[0] = 8'hE0; mem[1] = 8'h01;
        mem[2] = 8'h82; mem[3] = 8'h00; mem[4] = 8'h11;
        mem[5] = 8'h00; mem[6] = 8'h05;
        acc_zero = 1'b0;
        sync_model();
        run_and_compare("skip", 2, 0);
        check("skip_fetch", txn_at(4), {1'b0, 16'h0005, 8'h00});
        check("skip_next", exec_at(1), {16'h0005, 8'h00, 16'h0007});
        hold_reset();

        // Reset in the middle of a slow data-byte read, then a stray ack while idle.
        clear_mem();
        mem[0] = 8'h82; mem[1] = 8'h00; mem[2] = 8'h7F; mem[3] = 8'h00; mem[4] = 8'h05;
        sync_model();
        dmin = 3; dmax = 3;
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (mem_req && mem_addr == 16'h0002) found = 1;
        end
        check("rst_reach_data", found, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_idle("rst_mid");
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2 stale_ack = 1;
        repeat (3) @(negedge clk);
        #1;
        check_idle("stale");
        run_and_compare("restart", 2, 0);
        check("restart_first", exec_at(0), {16'h8200, 8'h7F, 16'h0003});
        hold_reset();

        for (int s = 0; s < 8; s++) begin
            rand_mem();
            sync_model();
            acc_zero  = 1'($urandom_range(0, 1));
            else_flag = 1'($urandom_range(0, 1));
            acc_lo    = 8'($urandom);
            dmin = 0; dmax = 3;
            run_and_compare($sformatf("rnd%0d", s), 30, 1);
            hold_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Fetch/execute controller for the 16-bit CPU core.
- Fetches each instruction, plus its optional data byte, over a shared 8-bit memory bus. Performs RAM operand reads and store writes.
- Presents the latched instruction and data byte to the instruction decoder with a one-cycle enable. Updates the PC for sequential flow, branches and conditional skips.

Parameters:
- ADDR_W, 16, width of the PC and the memory address.
- RESET_PC, 16'h0000, PC value loaded at reset.
- RAM_BASE, 16'h8000, base address for RAM operands; RAM address = RAM_BASE | inst[7:0].

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- run  in  1  1 = allow a new instruction fetch to start.
- mem_req  out  1  bus request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  bus address; stable while mem_req.
- mem_wdata  out  8  write byte; equals acc_lo.
- mem_rdata  in  8  read byte; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.
- dec_en  out  1  decoder enable; one-cycle pulse in EXEC.
- dec_inst  out  16  latched instruction word.
- dec_data  out  8  latched data byte (immediate or RAM).
- dec_branch, dec_store, dec_if  in  1 each  decoder inst_branch, inst_store, inst_if.
- dec_if_zero, dec_if_not_zero, dec_if_else, dec_if_not_else  in  1 each  decoder condition selects.
- dec_rhs  in  16  decoder rhs; the sign-extended offset when branching.
- acc_zero  in  1  accumulator == 0.
- else_flag  in  1  core else/carry flag.
- acc_lo  in  8  accumulator low byte, for stores.
- pc  out  ADDR_W  current PC.
- busy  out  1  1 in any state other than an idle FETCH_HI.

Behaviour:
- Reset (async assert): state=FETCH_HI, pc=RESET_PC. mem_req, mem_we, dec_en, busy = 0. dec_inst, dec_data, mem_addr = 0. An outstanding bus request is abandoned and mem_req drops immediately.
- Bus handshake:
  - The sequencer raises mem_req with address and we stable. It holds them until it samples mem_ack=1.
  - mem_req deasserts the cycle after the ack.
  - At most one request is outstanding. A mem_ack while mem_req=0 is ignored.
- Instruction format: big-endian. The high byte is at pc, the low byte at pc+1.
- States:
  - FETCH_HI: if run, read pc. On ack, inst[15:8] <= rdata and pc <= pc+1. If run=0, stay idle with busy=0.
  - FETCH_LO: read pc. On ack, inst[7:0] <= rdata and pc <= pc+1. Then compute the instruction's needs:
    - one_arg = inst[15:14]==2'b10.
    - Data needed if one_arg and inst[10:9]==2'b01 -> FETCH_DATA.
    - Else RAM read needed if one_arg, inst[10]=1 and inst[15:11]!=5'b10010 -> RAM_READ.
    - Else -> EXEC.
  - FETCH_DATA: read pc. On ack, data <= rdata and pc <= pc+1 -> EXEC.
  - RAM_READ: read RAM_BASE|inst[7:0]. On ack, data <= rdata -> EXEC. pc is unchanged.
  - EXEC: exactly one cycle with dec_en=1; decoder outputs are sampled this cycle.
    - dec_branch: pc <= pc + dec_rhs. Addition is modulo 2^ADDR_W, relative to the address after the instruction.
    - dec_store with inst[10]=1: -> STORE.
    - dec_if: take the condition. zero->acc_zero, not_zero->!acc_zero, else->else_flag, not_else->!else_flag. No select asserted means true. False -> SKIP_HI; true -> FETCH_HI.
    - Otherwise -> FETCH_HI.
  - STORE: write acc_lo to RAM_BASE|inst[7:0], sampled when the request is issued. On ack -> FETCH_HI.
  - SKIP_HI: read pc. On ack, pc <= pc+1 and capture the high byte -> SKIP_LO.
  - SKIP_LO: read pc. On ack, the skipped instruction is not executed and dec_en stays 0:
    - pc <= pc+2 if the skipped instruction is one-arg with data (captured bits [15:14]==2'b10 and [10:9]==2'b01).
    - pc <= pc+1 otherwise.
    - Then -> FETCH_HI.
- dec_en is never asserted outside EXEC. dec_inst and dec_data hold their values until the next fetch overwrites them.
- An if that skips another if skips only that one instruction; there is no chaining.
- PC wraps from 16'hFFFF to 16'h0000 silently.
- run=0 only blocks the start of a new fetch. An instruction already in progress always completes.
- Latency with a zero-wait bus (ack the cycle after req):
  - 2-byte ALU instruction: 5 cycles.
  - Data-byte instruction: 7 cycles.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum;
  - opcode field constants ONE_ARG_MASK=16'hC000, ONE_ARG_VAL=16'h8000, SRC_MASK=16'h0600, SRC_DATA=16'h0200, OP_STORE=5'b10010;
  - a function inst_len(hi_byte) returning 2 or 3.
- One natural sub-module: bus_port, the request/ack holder that owns mem_req, mem_we, mem_addr and the byte latch.

Test Plan:
- Reset, then release rst_n with run=1 and memory 0x0000:0x00,0x05 -> reads at 0,1. dec_en pulses once with dec_inst=16'h0005. pc=2, next fetch at 2.
- Instruction 0x82 0x00, then byte 0x7F at addr 2 -> three reads. dec_data=8'h7F, pc=3, one dec_en pulse.
- Instruction 0x84 0x10 -> read at 16'h8010 with rdata=8'hAA. dec_data=8'hAA, pc=2. Store 0x94 0x20 with acc_lo=8'h3C -> write 8'h3C to 16'h8020, no RAM read.
- Branch at pc=0x0100 with dec_rhs=16'hFFFE (-2) -> next fetch address 16'h0100.
- If with dec_if_zero=1 and acc_zero=0, followed by the 3-byte instruction 0x82 0x00 0x11 -> no dec_en for it, and the next fetch is at if_addr+5.
- Assert rst_n=0 mid-FETCH_DATA with a 3-cycle ack delay -> mem_req=0 immediately. After release, fetch restarts at RESET_PC; a stale ack is ignored.
